data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//   Memory-side responder for the data cache's miss/write-back port: a word-organised
//   backing RAM with fixed multi-cycle latency and a one-cycle ready pulse per access.
//   Accepts level read/write requests from the cache FSM. Performs RV32 byte/half/word
//   access with sign/zero extension, and models main-memory timing seen by the cache.
// PARAMETERS
//   ADDR_WIDTH   32    byte address width
//   DATA_WIDTH   32    data width; only 32 supported
//   DEPTH_WORDS  1024  RAM depth in 32-bit words; power of two
//   LATENCY      4     cycles from acceptance edge to ready; legal range 1..255
// PORTS
//   clk         in   1           rising-edge clock
//   rst_n       in   1           asynchronous active-low reset
//   mem_ctrl    in   3           RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   address     in   ADDR_WIDTH  byte address
//   write_data  in   DATA_WIDTH  store data; B/H use low bits
//   write_en    in   1           write request (level)
//   read_en     in   1           read request (level)
//   read_data   out  DATA_WIDTH  extended load result, registered
//   ready       out  1           one-cycle completion pulse
//   err         out  1           only with DMEM_ERR_EN; see CONFIGURATION
// BEHAVIOUR
//   - Reset: state IDLE, counter 0, ready=0, read_data=0, err=0; RAM contents not cleared.
//   - FSM: IDLE -> BUSY -> RESP -> IDLE.
//   - IDLE: at an edge with read_en|write_en, latch address, mem_ctrl, write_data
//     and request type. Load counter with LATENCY-1 and go to BUSY.
//   - Both enables high: treat as a write; read_en ignored.
//   - BUSY: counter decrements each edge. At the edge where it is 0, go to RESP:
//     commit the write or register the load result, and set ready=1.
//   - Ready timing: high for exactly one cycle, LATENCY edges after the acceptance edge.
//   - RESP: ready=0 at the next edge; return to IDLE. Inputs are ignored in BUSY/RESP.
//   - Throughput: one access per LATENCY+2 cycles. A request still held in IDLE is
//     accepted again; the requester must drop its enables on ready.
//   - Index: address[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so
//     out-of-range addresses wrap.
//   - Loads: B/BU select byte address[1:0]; H/HU select half address[1]; W returns the full word.
//   - Extension: B/H sign-extend; BU/HU zero-extend.
//   - Stores: B/H write only the addressed byte/half lanes; W writes all 4 lanes.
//   - Reserved mem_ctrl (011, 110, 111): loads act as W; stores are dropped, with ready still pulsing.
//   - Write responses leave read_data unchanged. read_data holds until the next load response.
//   - Reset mid-access (BUSY): the pending write is discarded, RAM is unmodified, and no ready pulse occurs.
// CONFIGURATION
//   DMEM_ERR_EN defined:
//     - Adds port err, valid only in the ready cycle.
//     - err=1 for misaligned access: H/HU with address[0]=1, W with address[1:0]!=0.
//     - Misaligned stores are suppressed. Misaligned loads return 0.
//   DMEM_ERR_EN undefined:
//     - No err port.
//     - Misaligned offsets are truncated: H uses address[1], W ignores address[1:0].
// TESTING
//   - Reset: rst_n=0 -> ready=0, read_data=0.
//     Release, hold idle 10 cycles -> ready stays 0.
//   - SW then LW: SW 0xDEADBEEF @0x40, then LW @0x40 -> ready exactly 4 cycles after
//     each acceptance edge; read_data=0xDEADBEEF.
//   - Extension: SB 0x80 @0x43, then LB @0x43 -> 0xFFFFFF80; LBU @0x43 -> 0x00000080.
//     After SH 0x1234 @0x42, LW @0x40 -> 0x1234BEEF.
//   - Simultaneous enables and wrap: read_en=write_en=1, SW 0x55 @0x40 + DEPTH_WORDS*4 ->
//     treated as a write; a later LW @0x40 returns 0x00000055.
//   - Reset mid-access: SW 0xAAAAAAAA @0x80, assert rst_n=0 at BUSY cycle 2 -> no ready.
//     After release, LW @0x80 returns the old value.
//   - DMEM_ERR_EN: LW @0x42 -> err=1 with ready, read_data=0.
//     SH @0x41 -> err=1 and the RAM word is unchanged.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised backing RAM for the data cache miss/write-back port: fixed LATENCY,
// one-cycle ready pulse, RV32 B/H/W loads and stores. Define DMEM_ERR_EN for misalignment errors.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            mem_ctrl,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_en,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  ready
`ifdef DMEM_ERR_EN
    ,
    output logic                  err
`endif
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_next;
    logic [7:0]        cnt;
    logic [IDX_W-1:0]  lat_idx;
    logic [1:0]        lat_off;
    logic [2:0]        lat_ctrl;
    logic [31:0]       lat_wdata;
    logic              lat_write;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept, commit;
    logic [31:0]       word, load_val, store_data;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [3:0]        lanes;
    logic              misaligned;
    logic              addr_unused;

    assign addr_unused = ^address[ADDR_WIDTH-1:IDX_W+2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: if (read_en || write_en) begin
                accept     = 1'b1;
                state_next = BUSY;
            end
            BUSY: if (cnt == '0) begin
                commit     = 1'b1;
                state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        word     = mem[lat_idx];
        byte_sel = word[7:0];
        case (lat_off)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = lat_off[1] ? word[31:16] : word[15:0];
        case (lat_ctrl)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = word;
        endcase
    end

    always_comb begin
`ifdef DMEM_ERR_EN
        misaligned = ((lat_ctrl == 3'b001 || lat_ctrl == 3'b101) && lat_off[0]) ||
                     (lat_ctrl == 3'b010 && lat_off != 2'b00);
`else
        misaligned = 1'b0;
`endif
        lanes      = '0;
        store_data = lat_wdata;
        case (lat_ctrl)
            3'b000, 3'b100: begin
                lanes      = 4'b0001 << lat_off;
                store_data = {4{lat_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                lanes      = lat_off[1] ? 4'b1100 : 4'b0011;
                store_data = {2{lat_wdata[15:0]}};
            end
            3'b010:  lanes = 4'b1111;
            default: lanes = '0;
        endcase
        if (misaligned) lanes = '0;
    end

    // RAM is not reset; an async reset during BUSY leaves state IDLE so no commit reaches it.
    always_ff @(posedge clk) begin
        if (commit && lat_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lanes[i]) mem[lat_idx][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lat_idx   <= '0;
            lat_off   <= '0;
            lat_ctrl  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            read_data <= '0;
            ready     <= 1'b0;
        end else begin
            ready <= commit;
            if (accept) begin
                cnt       <= 8'(LATENCY - 1);
                lat_idx   <= address[IDX_W+1:2];
                lat_off   <= address[1:0];
                lat_ctrl  <= mem_ctrl;
                lat_wdata <= write_data;
                lat_write <= write_en;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 8'd1;
            end
            if (commit && !lat_write) read_data <= misaligned ? '0 : load_val;
        end
    end

`ifdef DMEM_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= commit && misaligned;
    end
`endif
endmodule
